// File: rtl/sccb_slave.sv
// sccb_slave: SCCB/I2C responder standing in for the OV5640 end of the camera config bus.
// Define SCCB_AUTO_INC_EN to auto-increment the register pointer across write and read bursts.
module sccb_slave #(
    parameter logic [6:0]  DEV_ADDR = 7'h3C,
    parameter int          ADDR_W   = 8,
    parameter logic [15:0] CHIP_ID  = 16'h5640
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        sda_out_en,
    output logic        wr_vld,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy
);

`ifdef SCCB_AUTO_INC_EN
    localparam bit AUTO_INC = 1'b1;
`else
    localparam bit AUTO_INC = 1'b0;
`endif

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_DEV       = 4'd1;
    localparam logic [3:0] S_ACK_DEV   = 4'd2;
    localparam logic [3:0] S_ADDR_H    = 4'd3;
    localparam logic [3:0] S_ACK_AH    = 4'd4;
    localparam logic [3:0] S_ADDR_L    = 4'd5;
    localparam logic [3:0] S_ACK_AL    = 4'd6;
    localparam logic [3:0] S_WR_DATA   = 4'd7;
    localparam logic [3:0] S_ACK_WR    = 4'd8;
    localparam logic [3:0] S_RD_DATA   = 4'd9;
    localparam logic [3:0] S_RD_ACK    = 4'd10;
    localparam logic [3:0] S_WAIT_STOP = 4'd11;

    localparam logic [15:0] ID_HI_ADDR = 16'h300A;
    localparam logic [15:0] ID_LO_ADDR = 16'h300B;

    logic [7:0]  mem [2**ADDR_W];

    // [0],[1] synchronizer stages, [2] edge-detect history
    logic [2:0]  scl_q, scl_d, sda_q, sda_d;
    logic [3:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  addr_hi_q, addr_hi_d;
    logic [15:0] ptr_q, ptr_d;
    logic        rw_q, rw_d;
    logic        first_q, first_d;
    logic        mack_q, mack_d;
    logic        drive_q, drive_d;
    logic        busy_q, busy_d;
    logic        wr_vld_q, wr_vld_d;
    logic [15:0] wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        mem_we;

    logic        scl_rise, scl_fall, start_det, stop_det;
    logic [7:0]  byte_in;
    logic [15:0] ptr_inc;
    logic        is_id, accept, cur_bit, nxt_msb;

    function automatic logic [7:0] read_byte(input logic [15:0] p);
        if (p == ID_HI_ADDR)      return CHIP_ID[15:8];
        else if (p == ID_LO_ADDR) return CHIP_ID[7:0];
        else                      return mem[p[ADDR_W-1:0]];
    endfunction

    function automatic logic read_bit(input logic [15:0] p, input logic [2:0] idx);
        logic [7:0] b;
        b = read_byte(p);
        return b[idx];
    endfunction

    assign scl_rise  =  scl_q[1] & ~scl_q[2];
    assign scl_fall  = ~scl_q[1] &  scl_q[2];
    assign start_det =  scl_q[1] &  scl_q[2] &  sda_q[2] & ~sda_q[1];
    assign stop_det  =  scl_q[1] &  scl_q[2] & ~sda_q[2] &  sda_q[1];
    assign byte_in   = {shift_q[6:0], sda_q[1]};
    assign ptr_inc   = AUTO_INC ? ptr_q + 16'd1 : ptr_q;
    assign is_id     = (ptr_q == ID_HI_ADDR) || (ptr_q == ID_LO_ADDR);
    assign accept    = AUTO_INC || !first_q;
    assign cur_bit   = read_bit(ptr_q, 3'd7 - cnt_q[2:0]);
    assign nxt_msb   = read_bit(ptr_inc, 3'd7);

    always_comb begin
        scl_d     = {scl_q[1:0], scl_in};
        sda_d     = {sda_q[1:0], sda_in};
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        addr_hi_d = addr_hi_q;
        ptr_d     = ptr_q;
        rw_d      = rw_q;
        first_d   = first_q;
        mack_d    = mack_q;
        drive_d   = drive_q;
        busy_d    = busy_q;
        wr_vld_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        mem_we    = 1'b0;
        if (start_det) begin
            state_d = S_DEV;
            cnt_d   = '0;
            drive_d = 1'b0;
            busy_d  = 1'b1;
            first_d = 1'b0;
        end else if (stop_det) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            drive_d = 1'b0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_DEV, S_ADDR_H, S_ADDR_L, S_WR_DATA: begin
                    if (scl_rise && cnt_q != 4'd8) begin
                        shift_d = byte_in;
                        cnt_d   = cnt_q + 4'd1;
                        if (cnt_q == 4'd7) begin
                            case (state_q)
                                S_ADDR_H: addr_hi_d = byte_in;
                                S_ADDR_L: ptr_d = {addr_hi_q, byte_in};
                                S_WR_DATA: begin
                                    if (accept) begin
                                        wr_vld_d  = 1'b1;
                                        wr_addr_d = ptr_q;
                                        wr_data_d = byte_in;
                                        mem_we    = !is_id;
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end else if (scl_fall && cnt_q == 4'd8) begin
                        // ACK goes out on the fall that ends the 8th data bit
                        cnt_d   = '0;
                        drive_d = 1'b1;
                        case (state_q)
                            S_DEV: begin
                                if (shift_q[7:1] == DEV_ADDR) begin
                                    state_d = S_ACK_DEV;
                                    rw_d    = shift_q[0];
                                end else begin
                                    state_d = S_IDLE;
                                    drive_d = 1'b0;
                                end
                            end
                            S_ADDR_H: state_d = S_ACK_AH;
                            S_ADDR_L: state_d = S_ACK_AL;
                            default: begin
                                if (accept) begin
                                    state_d = S_ACK_WR;
                                end else begin
                                    state_d = S_WAIT_STOP;
                                    drive_d = 1'b0;
                                end
                            end
                        endcase
                    end
                end
                S_ACK_DEV, S_ACK_AH, S_ACK_AL, S_ACK_WR: begin
                    if (scl_fall) begin
                        drive_d = 1'b0;
                        case (state_q)
                            S_ACK_DEV: begin
                                if (rw_q) begin
                                    state_d = S_RD_DATA;
                                    drive_d = ~cur_bit;
                                end else begin
                                    state_d = S_ADDR_H;
                                end
                            end
                            S_ACK_AH: state_d = S_ADDR_L;
                            S_ACK_AL: state_d = S_WR_DATA;
                            default: begin
                                state_d = S_WR_DATA;
                                ptr_d   = ptr_inc;
                                if (!AUTO_INC) first_d = 1'b1;
                            end
                        endcase
                    end
                end
                S_RD_DATA: begin
                    if (scl_rise && cnt_q != 4'd8) begin
                        cnt_d = cnt_q + 4'd1;
                    end else if (scl_fall && cnt_q != 4'd0) begin
                        if (cnt_q == 4'd8) begin
                            state_d = S_RD_ACK;
                            cnt_d   = '0;
                            drive_d = 1'b0;
                        end else begin
                            drive_d = ~cur_bit;
                        end
                    end
                end
                S_RD_ACK: begin
                    if (scl_rise) begin
                        mack_d = sda_q[1];
                        cnt_d  = 4'd1;
                    end else if (scl_fall && cnt_q == 4'd1) begin
                        cnt_d = '0;
                        if (!mack_q) begin
                            state_d = S_RD_DATA;
                            ptr_d   = ptr_inc;
                            drive_d = ~nxt_msb;
                        end else begin
                            state_d = S_WAIT_STOP;
                            drive_d = 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_q     <= '1;
            sda_q     <= '1;
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            addr_hi_q <= '0;
            ptr_q     <= '0;
            rw_q      <= 1'b0;
            first_q   <= 1'b0;
            mack_q    <= 1'b0;
            drive_q   <= 1'b0;
            busy_q    <= 1'b0;
            wr_vld_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            scl_q     <= scl_d;
            sda_q     <= sda_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            addr_hi_q <= addr_hi_d;
            ptr_q     <= ptr_d;
            rw_q      <= rw_d;
            first_q   <= first_d;
            mack_q    <= mack_d;
            drive_q   <= drive_d;
            busy_q    <= busy_d;
            wr_vld_q  <= wr_vld_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[ptr_q[ADDR_W-1:0]] <= byte_in;
    end

    // an illegal START while driving must free the line immediately
    assign sda_out_en = drive_q & ~start_det;
    assign wr_vld     = wr_vld_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = busy_q;

endmodule
